// File: rtl/t_pkg.sv
// t_pkg: shared constants and types for the T(0,i) frame buffer.
//   BIT_WIDTH  : signed sample width of one T value
//   I          : entries per frame (addresses 0..I-1)
//   NU_VALUES  : nu columns per entry (fixed at 3)
//   ADDR_W     : entry address width
//   bank_state_t : per-bank lifecycle EMPTY -> FILLING -> FULL -> READING -> EMPTY
//   t_entry_t    : one stored entry, three signed samples
package t_pkg;

    localparam int BIT_WIDTH = 32;
    localparam int I         = 160;
    localparam int NU_VALUES = 3;
    localparam int ADDR_W    = $clog2(I);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    typedef struct packed {
        logic signed [BIT_WIDTH-1:0] nu2;
        logic signed [BIT_WIDTH-1:0] nu1;
        logic signed [BIT_WIDTH-1:0] nu0;
    } t_entry_t;

endpackage

// File: rtl/t_bank_ram.sv
// t_bank_ram: simple dual-port RAM holding two banks of ENTRIES words.
// Word index is bank*ENTRIES + addr, so exactly 2*ENTRIES words are used.
// Ports:
//   clk_in            : clock
//   we, wr_bank, wr_addr, wr_data : write port
//   re, rd_bank, rd_addr          : read request
//   rd_q              : read data, registered (1-cycle latency), held when re=0
// No reset on the array or read register so the memory maps onto block RAM.
module t_bank_ram
    import t_pkg::*;
#(
    parameter int DATA_W  = 3 * BIT_WIDTH,
    parameter int ENTRIES = I,
    parameter int AW      = ADDR_W
) (
    input  logic              clk_in,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic              rd_bank,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_q
);

    localparam int IW = $clog2(2 * ENTRIES);

    logic [DATA_W-1:0] mem [2*ENTRIES];

    function automatic logic [IW-1:0] word_idx(input logic bank, input logic [AW-1:0] addr);
        return bank ? (IW'(ENTRIES) + IW'(addr)) : IW'(addr);
    endfunction

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[word_idx(wr_bank, wr_addr)] <= wr_data;
        end
        if (re) begin
            rd_q <= mem[word_idx(rd_bank, rd_addr)];
        end
    end

endmodule

// File: rtl/t_frame_buffer.sv
// t_frame_buffer: ping-pong capture of per-frame T(0,i) results with a
// random-access 1-cycle-latency read port.
// Optional feature macro: T_FRAME_BUFFER_MAXABS_EN (adds maxabs_0..2 outputs).
// Ports:
//   clk_in, rst_in            : clock, synchronous active-high reset
//   in_valid, in_addr, in_data_0..2 : upstream stream, I consecutive beats per frame
//   frame_ready               : a committed frame is open for reading
//   rd_en, rd_addr, rd_nu     : read request; rd_data/rd_valid one cycle later
//   rd_done                   : consumer releases the current read bank
//   drop_count, drop_pulse    : saturating dropped-frame count and per-drop pulse
//   maxabs_0..2               : (macro only) max |value| per nu of the reading frame
//   bank_state_dbg            : {bank1 state, bank0 state} for observation
// Read handshake: a read is accepted when rd_en=1, frame_ready=1, rd_addr<I and
// rd_nu<3; exactly one cycle later rd_valid=1 with the data, otherwise rd_valid=0
// and rd_data=0. There is no backpressure on either side.
module t_frame_buffer #(
    parameter int BIT_WIDTH = t_pkg::BIT_WIDTH,
    parameter int I         = t_pkg::I,
    parameter int NU_VALUES = t_pkg::NU_VALUES,
    parameter int DROP_W    = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        in_valid,
    input  logic [$clog2(I)-1:0]        in_addr,
    input  logic signed [BIT_WIDTH-1:0] in_data_0,
    input  logic signed [BIT_WIDTH-1:0] in_data_1,
    input  logic signed [BIT_WIDTH-1:0] in_data_2,
    output logic                        frame_ready,
    input  logic                        rd_en,
    input  logic [$clog2(I)-1:0]        rd_addr,
    input  logic [1:0]                  rd_nu,
    output logic signed [BIT_WIDTH-1:0] rd_data,
    output logic                        rd_valid,
    input  logic                        rd_done,
    output logic [DROP_W-1:0]           drop_count,
    output logic                        drop_pulse,
`ifdef T_FRAME_BUFFER_MAXABS_EN
    output logic [BIT_WIDTH-1:0]        maxabs_0,
    output logic [BIT_WIDTH-1:0]        maxabs_1,
    output logic [BIT_WIDTH-1:0]        maxabs_2,
`endif
    output logic [3:0]                  bank_state_dbg
);

    localparam int AW = $clog2(I);
    localparam int CW = $clog2(I + 1);
    localparam int DW = 3 * BIT_WIDTH;
    localparam logic [CW-1:0] I_C  = CW'(I);
    localparam logic [1:0]    NU_C = 2'(NU_VALUES);

    t_pkg::bank_state_t bank_st [2];
    t_pkg::bank_state_t bank_nx [2];

    logic          in_valid_q;
    logic          wr_ptr, rd_ptr;
    logic          frame_ready_q;
    logic [CW-1:0] wr_cnt;
    logic          cap_on;   // current frame owns bank wr_ptr
    logic          cap_bad;  // current frame has already broken ordering

    logic          rise, fall, start_ok, cap_now, addr_ok, we, bad_set;
    logic          commit, abort, drop_ev, promote, rd_done_ok, rd_acc;
    logic [CW-1:0] exp_addr;
    logic [BIT_WIDTH-1:0] in_d [3];
    logic [DW-1:0] ram_q;
    logic          rd_valid_q;
    logic [1:0]    rd_nu_q;

    assign in_d[0] = in_data_0;
    assign in_d[1] = in_data_1;
    assign in_d[2] = in_data_2;

    assign rise = in_valid & ~in_valid_q;
    assign fall = ~in_valid & in_valid_q;

    // The EMPTY check uses the registered state, so a bank being freed by
    // rd_done in this very cycle does not accept a new frame.
    assign start_ok = rise & (bank_st[wr_ptr] == t_pkg::EMPTY);
    assign cap_now  = start_ok | (in_valid & ~rise & cap_on & ~cap_bad);
    assign exp_addr = rise ? '0 : wr_cnt;
    assign addr_ok  = (CW'(in_addr) == exp_addr) && (CW'(in_addr) < I_C);
    assign we       = cap_now & addr_ok;
    assign bad_set  = cap_now & ~addr_ok;

    assign commit  = fall & cap_on & ~cap_bad & (wr_cnt == I_C);
    assign abort   = fall & cap_on & ~commit;
    assign drop_ev = abort | (fall & ~cap_on);

    // Only the read-pointer bank can ever be READING, so frame_ready_q doubles
    // as "some bank is READING".
    assign rd_done_ok = rd_done & frame_ready_q;
    assign promote    = ~frame_ready_q & (bank_st[rd_ptr] == t_pkg::FULL);
    assign rd_acc     = rd_en & frame_ready_q & (CW'(rd_addr) < I_C) & (rd_nu < NU_C);

    // Bank lifecycle: write-side and read-side events always target different
    // banks (FILLING vs FULL/READING), so they can be applied together.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_nx[b] = bank_st[b];
            if (wr_ptr == 1'(b)) begin
                if (start_ok) bank_nx[b] = t_pkg::FILLING;
                if (commit)   bank_nx[b] = t_pkg::FULL;
                if (abort)    bank_nx[b] = t_pkg::EMPTY;
            end
            if (rd_ptr == 1'(b)) begin
                if (promote)    bank_nx[b] = t_pkg::READING;
                if (rd_done_ok) bank_nx[b] = t_pkg::EMPTY;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int b = 0; b < 2; b++) bank_st[b] <= t_pkg::EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) bank_st[b] <= bank_nx[b];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            in_valid_q    <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            frame_ready_q <= 1'b0;
            wr_cnt        <= '0;
            cap_on        <= 1'b0;
            cap_bad       <= 1'b0;
            drop_count    <= '0;
            drop_pulse    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_nu_q       <= '0;
        end else begin
            in_valid_q <= in_valid;
            if (rise) begin
                cap_on  <= start_ok;
                cap_bad <= bad_set;
                wr_cnt  <= CW'(we);
            end else begin
                if (bad_set) cap_bad <= 1'b1;
                if (we)      wr_cnt  <= wr_cnt + CW'(1);
                if (fall)    cap_on  <= 1'b0;
            end
            if (commit)     wr_ptr <= ~wr_ptr;
            if (rd_done_ok) rd_ptr <= ~rd_ptr;
            frame_ready_q <= promote | (frame_ready_q & ~rd_done_ok);
            drop_pulse    <= drop_ev;
            if (drop_ev && (drop_count != {DROP_W{1'b1}})) begin
                drop_count <= drop_count + DROP_W'(1);
            end
            rd_valid_q <= rd_acc;
            rd_nu_q    <= rd_nu;
        end
    end

    t_bank_ram #(
        .DATA_W  (DW),
        .ENTRIES (I),
        .AW      (AW)
    ) u_ram (
        .clk_in  (clk_in),
        .we      (we),
        .wr_bank (wr_ptr),
        .wr_addr (in_addr),
        .wr_data ({in_d[2], in_d[1], in_d[0]}),
        .re      (rd_acc),
        .rd_bank (rd_ptr),
        .rd_addr (rd_addr),
        .rd_q    (ram_q)
    );

    always_comb begin
        rd_data = '0;
        if (rd_valid_q) begin
            case (rd_nu_q)
                2'd0:    rd_data = ram_q[BIT_WIDTH-1:0];
                2'd1:    rd_data = ram_q[2*BIT_WIDTH-1:BIT_WIDTH];
                default: rd_data = ram_q[3*BIT_WIDTH-1:2*BIT_WIDTH];
            endcase
        end
    end

    assign rd_valid       = rd_valid_q;
    assign frame_ready    = frame_ready_q;
    assign bank_state_dbg = {bank_st[1], bank_st[0]};

`ifdef T_FRAME_BUFFER_MAXABS_EN
    logic [BIT_WIDTH-1:0] mx [2][3];

    // |most-negative| has no positive representation; clamp to max positive.
    function automatic logic [BIT_WIDTH-1:0] abs_sat(input logic [BIT_WIDTH-1:0] v);
        if (!v[BIT_WIDTH-1]) return v;
        if (v == {1'b1, {(BIT_WIDTH-1){1'b0}}}) return {1'b0, {(BIT_WIDTH-1){1'b1}}};
        return -v;
    endfunction

    function automatic logic [BIT_WIDTH-1:0] umax(input logic [BIT_WIDTH-1:0] a,
                                                  input logic [BIT_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Tracker of a bank is frozen once its frame commits: the bank is not
    // written again until it has gone EMPTY and restarted.
    always_ff @(posedge clk_in) begin
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) begin
                if (rst_in) begin
                    mx[b][k] <= '0;
                end else if (wr_ptr == 1'(b)) begin
                    if (we) begin
                        mx[b][k] <= umax(rise ? '0 : mx[b][k], abs_sat(in_d[k]));
                    end else if (start_ok) begin
                        mx[b][k] <= '0;
                    end
                end
            end
        end
    end

    assign maxabs_0 = frame_ready_q ? mx[rd_ptr][0] : '0;
    assign maxabs_1 = frame_ready_q ? mx[rd_ptr][1] : '0;
    assign maxabs_2 = frame_ready_q ? mx[rd_ptr][2] : '0;
`endif

endmodule

// File: doc/t_frame_buffer.md
Name: t_frame_buffer

Overview:
- Sits directly downstream of the T(0,i) stage.
- Captures its per-frame stream of I consecutive (address, 3×nu) results into a ping-pong buffer.
- Presents each completed frame to the next consumer through a random-access, 1-cycle-latency read port.
- Malformed frames (short, over-length, out-of-order) and frames arriving while both banks are occupied are dropped and counted. A dropped frame never corrupts a bank that is already committed.

Parameters:
- BIT_WIDTH, 32, signed sample width of each T value
- I, 160, entries per frame (addresses 0..I-1)
- NU_VALUES, 3, number of nu columns per entry (ports are fixed at 3; this value must be 3)
- DROP_W, 8, width of the saturating drop counter

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- in_valid  in  1  upstream output_valid; high for exactly I consecutive cycles per well-formed frame
- in_addr  in  $clog2(I)  upstream output_address
- in_data_0  in  BIT_WIDTH  signed T value, nu=0
- in_data_1  in  BIT_WIDTH  signed T value, nu=1
- in_data_2  in  BIT_WIDTH  signed T value, nu=2
- frame_ready  out  1  a committed frame is available to read
- rd_en  in  1  read request
- rd_addr  in  $clog2(I)  read entry index
- rd_nu  in  2  read column, 0..2
- rd_data  out  BIT_WIDTH  signed read result
- rd_valid  out  1  rd_data valid; one cycle after an accepted rd_en
- rd_done  in  1  consumer releases the current read bank (single-cycle pulse)
- drop_count  out  DROP_W  saturating count of dropped frames
- drop_pulse  out  1  one-cycle pulse per dropped frame

Behaviour:
- Reset:
  - Both banks go to EMPTY; write and read bank pointers = 0.
  - All outputs = 0: frame_ready, rd_data, rd_valid, drop_count, drop_pulse.
  - Reset mid-frame discards the partial frame with no drop count.
- Bank state per bank: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
- Frame start (in_valid rising edge):
  - If the write-pointer bank is EMPTY, it enters FILLING and the write count is cleared.
  - Otherwise the whole frame is discarded. At its end, drop_pulse fires and drop_count increments.
- While FILLING with in_valid high:
  - Expected address = write count.
  - If in_addr matches and is < I: store all three values at in_addr and increment the count.
  - Otherwise mark the frame bad and stop writing.
- Frame end (in_valid falling edge):
  - Good frame (count == I): bank goes FULL and the write pointer toggles.
  - Bad or short frame: bank returns to EMPTY, drop_pulse fires, drop_count increments (saturates at 2^DROP_W-1).
- Read promotion:
  - If no bank is READING and the read-pointer bank is FULL, it becomes READING on the next cycle.
  - frame_ready = (read-pointer bank is READING), registered.
- Reads:
  - rd_en is accepted only when frame_ready=1 and rd_addr<I and rd_nu<3.
  - The cycle after an accepted read: rd_valid=1 and rd_data = stored value.
  - The cycle after a non-accepted read or no read: rd_valid=0, rd_data=0.
- rd_done:
  - Ignored unless frame_ready=1.
  - When honoured, the READING bank becomes EMPTY, the read pointer toggles, and frame_ready falls on the next cycle.
  - A read accepted in the same cycle as rd_done still returns valid data.
- Simultaneous events:
  - Frame commit and rd_done in the same cycle are both applied.
  - A frame starting in the same cycle a bank is freed by rd_done is dropped: the EMPTY check uses the pre-edge state.
- Data: stored bit-exact; no scaling or saturation.
- Latency: first entry readable 2 cycles after the falling edge of in_valid (commit, then promotion).

Optional Feature:
- Macro: T_FRAME_BUFFER_MAXABS_EN.
- Defined:
  - Adds outputs maxabs_0, maxabs_1, maxabs_2 (BIT_WIDTH, unsigned), one per nu.
  - Each holds the largest |value| of the currently READING frame.
  - Tracked per bank during filling and latched on commit; 0 when frame_ready=0.
  - |most-negative| saturates to 2^(BIT_WIDTH-1)-1.
- Undefined: the ports and the logic are absent.

Decomposition:
- Package t_pkg:
  - Constants BIT_WIDTH, I, NU_VALUES, ADDR_W=$clog2(I).
  - bank_state_t enum {EMPTY, FILLING, FULL, READING}.
  - t_entry_t packed struct of 3 signed BIT_WIDTH fields.
- Sub-module t_bank_ram:
  - Simple dual-port RAM of 2*I entries of t_entry_t, indexed by {bank, addr}.
  - One write port, one registered read port with 1-cycle latency. BRAM-inferable.

Test Plan:
- Single frame: in_addr 0..159 with in_data_0=addr, in_data_1=-addr, in_data_2=addr<<8 -> frame_ready=1 two cycles after in_valid falls. Read (37,1) -> rd_valid next cycle with rd_data=-37. Read (159,2) -> 40704.
- Short frame: 100 valid cycles -> drop_pulse once, drop_count=1, frame_ready stays 0.
- Back-to-back frames A, B, C with no rd_done -> A and B are committed and C is dropped (drop_count=1). rd_done -> B readable; reading (5,0) returns B's value.
- Out-of-order address (entry 50 presented as 51) -> frame dropped; the previously committed bank contents are unchanged.
- rd_done in the same cycle as rd_en at (10,0) -> rd_valid=1 with correct data; frame_ready=0 the next cycle.
- Reset asserted at entry 80 of a frame -> all outputs 0; a following clean frame commits normally with drop_count=0.
